// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared types for the pipeline stall/flush controller
package stall_ctrl_pkg;

  typedef enum logic {
    RUN = 1'b0,
    LU2 = 1'b1
  } stall_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } stall_t;

endpackage

// File: rtl/stall_ctrl_shadow_reg.sv
// rtl/stall_ctrl_shadow_reg.sv - shadow write-back register captured on the first cycle of a freeze
module shadow_reg #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_e,
  input  logic            w_stat,
  input  logic            w_reg_write,
  input  logic [RA_W-1:0] w_dst,
  input  logic [XLEN-1:0] w_wd,
  output logic [RA_W-1:0] s_wa,
  output logic            s_has_value,
  output logic [XLEN-1:0] s_wd
);

  logic [RA_W-1:0] swa_q, swa_d;
  logic [XLEN-1:0] swd_q, swd_d;
  logic            has_q, has_d;
  logic            capture;

  // W is bubbled after the first frozen cycle, so only that cycle can capture
  assign capture = stall_e & ~has_q & w_stat & w_reg_write & (w_dst != '0);

  always_comb begin
    swa_d = swa_q;
    swd_d = swd_q;
    has_d = has_q;
    if (capture) begin
      swa_d = w_dst;
      swd_d = w_wd;
      has_d = 1'b1;
    end else if (!stall_e) begin
      has_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swa_q <= '0;
      swd_q <= '0;
      has_q <= 1'b0;
    end else begin
      swa_q <= swa_d;
      swd_q <= swd_d;
      has_q <= has_d;
    end
  end

  assign s_wa        = swa_q;
  assign s_has_value = has_q;
  assign s_wd        = swd_q;

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - hazard detection and per-stage stall/flush control for the 5-stage core
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] Dra1,
  input  logic [RA_W-1:0] Dra2,
  input  logic            DUse1,
  input  logic            DUse2,
  input  logic            DBranch,
  input  logic            DBranchTaken,
  input  logic [RA_W-1:0] Edst,
  input  logic            ERegWrite,
  input  logic            EMemRead,
  input  logic [RA_W-1:0] Wdst,
  input  logic            WRegWrite,
  input  logic            WStat,
  input  logic [XLEN-1:0] Wwd,
  input  logic            imem_busy,
  input  logic            dmem_busy,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            flushD,
  output logic            flushE,
  output logic            flushW,
  output logic [RA_W-1:0] Swa,
  output logic            ShasValue,
  output logic [XLEN-1:0] Sregwd
);

  stall_state_t state_q, state_d;
  stall_t       ctl;
  logic         hit_e, lu, br1, br2, hz_stall;

  assign hit_e = ERegWrite & (Edst != '0) &
                 ((DUse1 & (Edst == Dra1)) | (DUse2 & (Edst == Dra2)));
  assign lu    = hit_e & EMemRead;
  assign br1   = hit_e & DBranch & ~EMemRead;
  assign br2   = lu & DBranch;

  // In LU2 the load has moved to M, so the hazard terms no longer see it
  assign hz_stall = (state_q == LU2) | lu | br1;

  always_comb begin
    ctl = '0;
    if (dmem_busy) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.stall_m = 1'b1;
      ctl.flush_w = 1'b1;
    end else if (hz_stall) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.flush_e = 1'b1;
    end else begin
      ctl.stall_f = imem_busy;
      ctl.flush_d = imem_busy | DBranchTaken;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!dmem_busy) begin
      if (state_q == LU2) state_d = RUN;
      else if (br2)       state_d = LU2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign stallF = ctl.stall_f;
  assign stallD = ctl.stall_d;
  assign stallE = ctl.stall_e;
  assign stallM = ctl.stall_m;
  assign flushD = ctl.flush_d;
  assign flushE = ctl.flush_e;
  assign flushW = ctl.flush_w;

  shadow_reg #(
    .XLEN(XLEN),
    .RA_W(RA_W)
  ) u_shadow (
    .clk         (clk),
    .reset       (reset),
    .stall_e     (ctl.stall_e),
    .w_stat      (WStat),
    .w_reg_write (WRegWrite),
    .w_dst       (Wdst),
    .w_wd        (Wwd),
    .s_wa        (Swa),
    .s_has_value (ShasValue),
    .s_wd        (Sregwd)
  );

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage core; it sits beside the forwarding unit.
- Detects load-use and branch-operand hazards that forwarding cannot resolve, and freezes the pipeline while instruction or data memory is busy.
- Drives per-stage stall/flush controls.
- Owns the shadow write-back register whose outputs (Swa, ShasValue, Sregwd) are the lowest-priority E-stage forwarding source.

Parameters:
- XLEN, 64, datapath width of Sregwd/Wwd
- RA_W, 5, register address width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- Dra1  in  RA_W  D-stage source reg 1
- Dra2  in  RA_W  D-stage source reg 2
- DUse1  in  1  D instruction reads Dra1
- DUse2  in  1  D instruction reads Dra2
- DBranch  in  1  D instruction compares operands in D (branch/jalr)
- DBranchTaken  in  1  D resolved a redirect this cycle
- Edst  in  RA_W  E-stage destination
- ERegWrite  in  1  E writes a register
- EMemRead  in  1  E is a load
- Wdst  in  RA_W  W-stage destination
- WRegWrite  in  1  W writes a register
- WStat  in  1  W holds a valid instruction
- Wwd  in  XLEN  W write-back data
- imem_busy  in  1  fetch request outstanding
- dmem_busy  in  1  M-stage memory access outstanding
- stallF, stallD, stallE, stallM  out  1 each  hold the named stage register
- flushD, flushE, flushW  out  1 each  load a bubble into the named stage register
- Swa  out  RA_W  shadow destination
- ShasValue  out  1  shadow valid
- Sregwd  out  XLEN  shadow data

Behaviour:
- Reset is asynchronous: the FSM returns to RUN and Swa, ShasValue and Sregwd clear to 0. Stall/flush outputs are combinational from the FSM state and inputs; with idle inputs in RUN they are all 0.
- Hazard terms, computed combinationally:
  - hitE = ERegWrite & (Edst!=0) & ((DUse1 & Edst==Dra1) | (DUse2 & Edst==Dra2)).
  - lu = hitE & EMemRead.
  - br1 = hitE & DBranch & ~EMemRead (ALU result needed in D next cycle; 1 stall cycle).
  - br2 = lu & DBranch (load data is only forwardable from W; 2 stall cycles).
- FSM states:
  - RUN: on (lu | br1) with ~dmem_busy, assert stallF, stallD, flushE. If br2, next state is LU2; otherwise stay in RUN.
  - LU2: the load is now in M and E holds a bubble. Assert stallF, stallD, flushE unconditionally. Next state is RUN.
- Priority, highest first:
  1. dmem_busy: stallF=stallD=stallE=stallM=1, flushW=1, flushE=0. The FSM holds its state.
  2. Load-use / branch stall: as per the FSM above.
  3. imem_busy: stallF=1, flushD=1.
  4. DBranchTaken: flushD=1.
- stallD=1 suppresses flushD. DBranchTaken is ignored while stallD=1, because D re-evaluates the branch later.
- Shadow register, updated on posedge:
  - If stallE & ~ShasValue & WStat & WRegWrite & (Wdst!=0): capture Swa<=Wdst, Sregwd<=Wwd, ShasValue<=1.
  - Else if ~stallE: ShasValue<=0. Swa and Sregwd may hold stale values while ShasValue=0.
  - Capture happens only once per freeze. This is the first cycle, because W is bubbled afterwards.
- Multiple events in one cycle:
  - dmem_busy rising during LU2: LU2 is held and resumes after busy drops.
  - reset during LU2: the FSM goes to RUN immediately.

Decomposition:
- Place the following in pipes as a typedef: stall_t packing stallF..stallM and flushD..flushW. The controller exposes them as individual ports.
- Place the following in pipes as an enum: stall_state_t {RUN, LU2}.
- Sub-module shadow_reg holds the capture/clear register (RA_W+XLEN+1 bits). All remaining logic stays in stall_ctrl.

Test Plan:
- Load-use: E=ld x5, D uses x5 (not a branch) -> exactly 1 cycle of stallF/stallD/flushE; the FSM stays in RUN.
- Load feeding a branch: E=ld x7, D=beq x7,x0 -> 2 consecutive stall cycles (RUN then LU2), then RUN with no stall.
- ALU result feeding a branch: E=add x3, D=bne x3,x1 -> 1 stall cycle. Repeat with Edst=0 -> no stall.
- Data-memory freeze: dmem_busy for 3 cycles while W writes x9=0xDEAD_BEEF -> stallF..stallM=1 and flushW=1 in all 3 cycles. ShasValue=1, Swa=9, Sregwd=0xDEADBEEF from the 2nd cycle onward. ShasValue clears the cycle after busy drops.
- Fetch miss plus redirect: imem_busy=1 with DBranchTaken=1 -> stallF=1, flushD=1. Then add lu=1 -> stallD=1 and flushD=0.
- Reset mid-LU2: assert reset asynchronously -> the state returns to RUN and ShasValue=0 before the next clock edge.
